// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port synchronous RAM.
package ram_pkg;

  // Clear controller states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Same-address read-during-write behaviour
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear sequencer: walks every word writing zero, then idles until the
// next clear request. busy is registered and tracks the CLEAR state.
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_go,
  output logic             clr_we,
  output logic [CNT_W-1:0] clr_addr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  clr_state_e       state;
  logic [CNT_W-1:0] clr_ptr;

  // A request is only honoured from READY; requests during CLEAR are ignored
  assign clr_go   = (state == ST_READY) && clr_req && !rst;
  // Clearing writes start on the first edge after rst falls
  assign clr_we   = (state == ST_CLEAR) && !rst;
  assign clr_addr = clr_ptr;

  // Clear FSM with registered busy; reset restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST) begin
            state   <= ST_READY;
            clr_ptr <= '0;
            busy    <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        ST_READY: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_sync_dp.sv
// Simple dual-port synchronous RAM with byte enables, configurable read
// latency, selectable read-during-write behaviour and a self-clearing sweep.
module ram_sync_dp
  import ram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy
);

  localparam int              NBYTES  = DATA_W / 8;
  localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_go, clr_we;
  logic [MEM_AW-1:0] clr_addr;
  logic [MEM_AW-1:0] widx, ridx;
  logic              wr_ok, rd_in_range, rd_acc, rd_take;
  logic [DATA_W-1:0] wr_merged, rd_word;

  ram_clr_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (MEM_AW)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_go   (clr_go),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign widx        = wr_addr[MEM_AW-1:0];
  assign ridx        = rd_addr[MEM_AW-1:0];
  assign wr_ok       = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;
  assign rd_acc      = rd_en && !busy;
  // A read landing on the same edge as an accepted clear is flushed too
  assign rd_take     = rd_acc && !clr_go;

  // Byte lanes not enabled keep the stored value
  for (genvar b = 0; b < NBYTES; b++) begin : g_merge
    assign wr_merged[b*8 +: 8] = wr_be[b] ? wr_data[b*8 +: 8] : mem[widx][b*8 +: 8];
  end

  // Storage update: the clear sweep owns the array while busy
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (wr_ok)
      mem[widx] <= wr_merged;
  end

  // Read word selection: out-of-range reads return 0, optional write bypass
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[ridx];
      if (RDW_MODE == RDW_NEW && wr_ok && (wr_addr == rd_addr))
        rd_word = wr_merged;
    end
  end

  // Read pipeline: data registers only load alongside a valid so rd_data
  // holds between pulses
  logic [RD_LAT:1]   vld_pipe;
  logic [DATA_W-1:0] dat_pipe [RD_LAT:1];

  for (genvar s = 1; s <= RD_LAT; s++) begin : g_stage
    if (s == 1) begin : g_first
      // First stage captures the selected word
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe[1] <= 1'b0;
          dat_pipe[1] <= '0;
        end else begin
          vld_pipe[1] <= rd_take;
          if (rd_take) dat_pipe[1] <= rd_word;
        end
      end
    end else begin : g_next
      // Later stages shift forward; a clear flushes in-flight reads
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe[s] <= 1'b0;
          dat_pipe[s] <= '0;
        end else begin
          vld_pipe[s] <= vld_pipe[s-1] && !clr_go;
          if (vld_pipe[s-1] && !clr_go) dat_pipe[s] <= dat_pipe[s-1];
        end
      end
    end
  end

  assign rd_valid = vld_pipe[RD_LAT];
  assign rd_data  = dat_pipe[RD_LAT];

endmodule

// File: tb/tb_ram_sync_dp.sv
// Directed bench for ram_sync_dp. Three instances share one stimulus bus:
//   u0: DEPTH 16,  RD_LAT 1, old-data read-during-write
//   u1: DEPTH 16,  RD_LAT 2, new-data read-during-write
//   u2: DEPTH 200, RD_LAT 1, old-data read-during-write
module tb_ram_sync_dp;

  logic        clk = 1'b0;
  logic        rst, clr_req, wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic        rd_valid0, rd_valid1, rd_valid2;
  logic        busy0, busy1, busy2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_sync_dp #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0));

  ram_sync_dp #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .RD_LAT(2), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1));

  ram_sync_dp #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .RD_LAT(1), .RDW_MODE(0)) u2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int n, n2;
    bit drop;
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    step(); step();
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b want 1", busy0); end
    tests++; if (rd_valid0 !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", rd_valid0); end
    tests++; if (rd_data0 !== 32'h0) begin fails++; $display("FAIL rst_data: got %h want 0", rd_data0); end
    // partial clear, then reset again: the sweep must restart
    rst = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0; drop = 0;
    rd_en = 1'b1; rd_addr = 8'd0;
    while (busy0 && n < 100) begin
      step(); n++;
      if (rd_valid0 || rd_valid1 || rd_valid2) drop = 1;
    end
    rd_en = 1'b0;
    tests++; if (n !== 16) begin fails++; $display("FAIL clear_len16: got %0d want 16", n); end
    tests++; if (drop !== 1'b0) begin fails++; $display("FAIL busy_rd_drop: got %b want 0", drop); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL busy1_fall: got %b want 0", busy1); end
    n2 = n;
    while (busy2 && n2 < 300) begin step(); n2++; end
    tests++; if (n2 !== 200) begin fails++; $display("FAIL clear_len200: got %0d want 200", n2); end
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 8'(a);
      step();
      tests++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0) begin
        fails++; $display("FAIL rst_read addr %0d: got v=%b d=%h want v=1 d=0", a, rd_valid0, rd_data0);
      end
    end
    rd_en = 1'b0;
    step();
    tests++; if (rd_valid0 !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", rd_valid0); end
    step();
  endtask

  task automatic test_byte_en();
    do_write(8'd3, 32'hAABBCCDD, 4'hF);
    do_write(8'd3, 32'h11223344, 4'b0101);
    rd_en = 1'b1; rd_addr = 8'd3;
    step();
    rd_en = 1'b0;
    tests++; if (rd_valid0 !== 1'b1 || rd_data0 !== 32'hAA22CC44) begin
      fails++; $display("FAIL byte_en u0: got v=%b d=%h want v=1 d=aa22cc44", rd_valid0, rd_data0); end
    step();
    tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hAA22CC44) begin
      fails++; $display("FAIL byte_en u1: got v=%b d=%h want v=1 d=aa22cc44", rd_valid1, rd_data1); end
    tests++; if (rd_valid0 !== 1'b0 || rd_data0 !== 32'hAA22CC44) begin
      fails++; $display("FAIL hold u0: got v=%b d=%h want v=0 d=aa22cc44", rd_valid0, rd_data0); end
  endtask

  task automatic test_rdw();
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'h5A; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 8'd7;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    tests++; if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0) begin
      fails++; $display("FAIL rdw_old: got v=%b d=%h want v=1 d=0", rd_valid0, rd_data0); end
    step();
    tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h5A) begin
      fails++; $display("FAIL rdw_new: got v=%b d=%h want v=1 d=5a", rd_valid1, rd_data1); end
    rd_en = 1'b1; rd_addr = 8'd7;
    step();
    rd_en = 1'b0;
    tests++; if (rd_data0 !== 32'h5A) begin
      fails++; $display("FAIL rdw_after: got %h want 5a", rd_data0); end
    step(); step();
  endtask

  task automatic test_latency();
    do_write(8'd0, 32'h10, 4'hF);
    do_write(8'd1, 32'h21, 4'hF);
    do_write(8'd2, 32'h32, 4'hF);
    step(); step();
    rd_en = 1'b1; rd_addr = 8'd0;
    step();
    tests++; if (rd_valid1 !== 1'b0) begin fails++; $display("FAIL lat_early: got %b want 0", rd_valid1); end
    rd_addr = 8'd1;
    step();
    tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h10) begin
      fails++; $display("FAIL lat_0: got v=%b d=%h want v=1 d=10", rd_valid1, rd_data1); end
    rd_addr = 8'd2;
    step();
    rd_en = 1'b0;
    tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h21) begin
      fails++; $display("FAIL lat_1: got v=%b d=%h want v=1 d=21", rd_valid1, rd_data1); end
    step();
    tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h32) begin
      fails++; $display("FAIL lat_2: got v=%b d=%h want v=1 d=32", rd_valid1, rd_data1); end
    step();
    tests++; if (rd_valid1 !== 1'b0 || rd_data1 !== 32'h32) begin
      fails++; $display("FAIL lat_end: got v=%b d=%h want v=0 d=32", rd_valid1, rd_data1); end
  endtask

  task automatic test_depth();
    logic [7:0] probe [4];
    logic [31:0] want [4];
    probe = '{8'd50, 8'd122, 8'd199, 8'd3};
    want  = '{32'h0, 32'h0, 32'h0, 32'hAA22CC44};
    do_write(8'd250, 32'hFF, 4'hF);
    rd_en = 1'b1; rd_addr = 8'd250;
    step();
    tests++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin
      fails++; $display("FAIL oob_read: got v=%b d=%h want v=1 d=0", rd_valid2, rd_data2); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = probe[i];
      step();
      tests++; if (rd_valid2 !== 1'b1 || rd_data2 !== want[i]) begin
        fails++; $display("FAIL oob_keep addr %0d: got %h want %h", probe[i], rd_data2, want[i]); end
    end
    rd_en = 1'b0;
    step(); step();
  endtask

  task automatic test_runtime_clear();
    int n;
    bit flag;
    do_write(8'd5, 32'h55AA55AA, 4'hF);
    rd_en = 1'b1; rd_addr = 8'd5;
    step();
    rd_en = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    tests++; if (rd_valid1 !== 1'b0) begin fails++; $display("FAIL flush: got %b want 0", rd_valid1); end
    tests++; if (busy1 !== 1'b1) begin fails++; $display("FAIL clr_busy: got %b want 1", busy1); end
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'h12345678; wr_be = 4'hF;
    n = 0; flag = 0;
    while (busy1 && n < 100) begin
      clr_req = (n == 5);
      step(); n++;
      wr_en = 1'b0;
      if (rd_valid0 || rd_valid1) flag = 1;
    end
    clr_req = 1'b0;
    tests++; if (n !== 16) begin fails++; $display("FAIL rt_clear_len: got %0d want 16", n); end
    tests++; if (flag !== 1'b0) begin fails++; $display("FAIL rt_no_valid: got %b want 0", flag); end
    rd_en = 1'b1; rd_addr = 8'd5;
    step();
    rd_en = 1'b0;
    tests++; if (rd_valid0 !== 1'b1 || rd_data0 !== 32'h0) begin
      fails++; $display("FAIL rt_addr5 u0: got v=%b d=%h want v=1 d=0", rd_valid0, rd_data0); end
    step();
    tests++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
      fails++; $display("FAIL rt_addr5 u1: got v=%b d=%h want v=1 d=0", rd_valid1, rd_data1); end
  endtask

  initial begin
    test_reset();
    test_byte_en();
    test_rdw();
    test_latency();
    test_depth();
    test_runtime_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ram_sync_dp.md
RAM_SYNC_DP -- requirements
Module: ram_sync_dp

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width; multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 256, word count; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter RDW_MODE, default 0, same-address read-during-write: 0 = old data, 1 = new data.
REQ-006 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port clr_req  input  1  one-cycle pulse requesting a full memory clear.
REQ-009 SHALL have port wr_en  input  1  write strobe.
REQ-010 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-011 SHALL have port wr_data  input  DATA_W  write data.
REQ-012 SHALL have port wr_be  input  DATA_W/8  byte enables; bit i gates byte i.
REQ-013 SHALL have port rd_en  input  1  read strobe.
REQ-014 SHALL have port rd_addr  input  ADDR_W  read address.
REQ-015 SHALL have port rd_data  output  DATA_W  registered read data.
REQ-016 SHALL have port rd_valid  output  1  rd_data qualifier, high for one cycle per accepted read.
REQ-017 SHALL have port busy  output  1  clear in progress; accesses not accepted.

Function
REQ-018 SHALL implement a two-state FSM: CLEAR (writes 0 to address clr_ptr, increments clr_ptr by 1 per cycle) and READY.
REQ-019 SHALL go from CLEAR to READY in the cycle after clr_ptr == DEPTH-1 is written; a full clear takes exactly DEPTH cycles.
REQ-020 SHALL go from READY to CLEAR on clr_req, with clr_ptr = 0; clr_req in CLEAR is ignored.
REQ-021 SHALL drive busy = 1 exactly while the FSM is in CLEAR.
REQ-022 SHALL accept a write only when wr_en = 1, busy = 0 and wr_addr < DEPTH; bytes with wr_be[i] = 0 keep their old value.
REQ-023 SHALL accept a read only when rd_en = 1 and busy = 0; dropped reads produce no rd_valid.
REQ-024 SHALL present rd_data with rd_valid = 1 exactly RD_LAT cycles after the accepting edge; back-to-back reads give back-to-back valids.
REQ-025 SHALL return 0 for an accepted read with rd_addr >= DEPTH.
REQ-026 SHALL, for a simultaneous same-address read and write, return the pre-write word when RDW_MODE = 0 and the byte-merged new word when RDW_MODE = 1.
REQ-027 SHALL hold rd_data between valids; rd_valid is 0 when no read is accepted.
REQ-028 SHALL flush reads already in the read pipeline when clr_req is accepted (no rd_valid afterwards).

Reset
REQ-029 SHALL, while rst = 1: rd_data = 0, rd_valid = 0, read pipeline flushed, FSM = CLEAR, clr_ptr = 0, busy = 1.
REQ-030 SHALL treat rst in mid-clear as a restart of the clear from address 0.
REQ-031 SHALL begin clearing on the first edge after rst falls; busy falls DEPTH cycles later.

Structure
REQ-032 SHALL place the FSM state type and the RDW_OLD/RDW_NEW constants in shared package ram_pkg.
REQ-033 SHALL implement the FSM and clr_ptr in the sub-module ram_clr_ctrl; the storage array and read pipeline live in ram_sync_dp.

Verification
REQ-034 SHALL cover reset: release rst with DEPTH=16 -> busy high 16 cycles; then read all 16 addresses -> all 0.
REQ-035 SHALL cover byte enables: DATA_W=32, write 0xAABBCCDD to addr 3, then 0x11223344 with be=0b0101 -> read addr 3 returns 0xAA22CC44.
REQ-036 SHALL cover read during write: same-address read and write of 0x5A over 0x00 -> RDW_MODE=0 returns 0x00; RDW_MODE=1 returns 0x5A.
REQ-037 SHALL cover latency: RD_LAT=2, reads of addrs 0,1,2 on consecutive cycles -> three consecutive rd_valid pulses starting 2 cycles later, data in order.
REQ-038 SHALL cover runtime clear: pulse clr_req with one read in flight and a write to addr 5 during busy -> no rd_valid, addr 5 reads 0 after busy falls.
REQ-039 SHALL cover the DEPTH bound: DEPTH=200, ADDR_W=8, write 0xFF to addr 250 -> read addr 250 returns 0, and no in-range word changes.
